// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative multiply/divide unit owning the HI/LO registers.
// Runs a shift-add multiply or a restoring divide, one bit per cycle, then
// applies sign correction and writes HI/LO. Every operation takes the same
// number of cycles, including divide-by-zero.
module muldiv_sequencer #(
    parameter int NB_DATA  = 32,
    parameter int NB_OP    = 2,
    parameter int NB_COUNT = 6
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_start,
    input  logic [NB_OP-1:0]   i_op,
    input  logic [NB_DATA-1:0] i_rs_data,
    input  logic [NB_DATA-1:0] i_rt_data,
    input  logic               i_flush,
    input  logic               i_hi_we,
    input  logic               i_lo_we,
    input  logic [NB_DATA-1:0] i_wdata,
    output logic [NB_DATA-1:0] o_hi,
    output logic [NB_DATA-1:0] o_lo,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam logic [NB_COUNT-1:0] LAST_ITER = NB_COUNT'(NB_DATA - 1);

    state_t state;
    state_t next_state;

    logic load;
    logic step;
    logic commit;
    logic hi_write;
    logic lo_write;

    // Operand/accumulator state. For a multiply, opa holds the multiplicand and
    // opb the multiplier (shifted right). For a divide, opa holds the dividend
    // (shifted left, feeding bits into the remainder) and opb the divisor.
    logic [NB_DATA-1:0]   opa;
    logic [NB_DATA-1:0]   opb;
    logic [2*NB_DATA-1:0] acc;
    logic [NB_COUNT-1:0]  count;
    logic                 is_div;
    logic                 sign_a;
    logic                 sign_b;
    logic                 dbz;

    logic                 signed_op;
    logic [NB_DATA-1:0]   abs_rs;
    logic [NB_DATA-1:0]   abs_rt;
    logic [NB_DATA-1:0]   mul_addend;
    logic [NB_DATA:0]     mul_sum;
    logic [NB_DATA:0]     div_shift;
    logic                 div_ge;
    logic [NB_DATA-1:0]   div_sub;
    logic [NB_DATA-1:0]   rem_next;
    logic [2*NB_DATA-1:0] prod_fixed;
    logic [NB_DATA-1:0]   quo;
    logic [NB_DATA-1:0]   rem;
    logic [NB_DATA-1:0]   res_hi;
    logic [NB_DATA-1:0]   res_lo;

    // State register plus the registered busy flag, which looks ahead at next_state.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state  <= IDLE;
            o_busy <= 1'b0;
        end else begin
            state  <= next_state;
            o_busy <= (next_state != IDLE);
        end
    end

    // Next-state logic and control strobes; a flush aborts RUN/FIX and masks a start.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        commit     = 1'b0;
        hi_write   = 1'b0;
        lo_write   = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    if (!i_flush) begin
                        next_state = RUN;
                        load       = 1'b1;
                    end
                end else begin
                    hi_write = i_hi_we;
                    lo_write = i_lo_we;
                end
            end
            RUN: begin
                if (i_flush) begin
                    next_state = IDLE;
                end else begin
                    step = 1'b1;
                    if (count == LAST_ITER) begin
                        next_state = FIX;
                    end
                end
            end
            FIX: begin
                next_state = IDLE;
                commit     = !i_flush;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // One iteration of the multiply/divide datapath plus the final sign correction.
    always_comb begin
        signed_op  = ~i_op[0];
        abs_rs     = (signed_op && i_rs_data[NB_DATA-1]) ? -i_rs_data : i_rs_data;
        abs_rt     = (signed_op && i_rt_data[NB_DATA-1]) ? -i_rt_data : i_rt_data;

        mul_addend = opb[0] ? opa : '0;
        mul_sum    = {1'b0, acc[2*NB_DATA-1:NB_DATA]} + {1'b0, mul_addend};

        div_shift  = {acc[2*NB_DATA-1:NB_DATA], opa[NB_DATA-1]};
        div_ge     = (div_shift >= {1'b0, opb});
        div_sub    = div_shift[NB_DATA-1:0] - opb;
        rem_next   = div_ge ? div_sub : div_shift[NB_DATA-1:0];

        prod_fixed = (sign_a ^ sign_b) ? -acc : acc;
        quo        = acc[NB_DATA-1:0];
        rem        = acc[2*NB_DATA-1:NB_DATA];

        if (is_div) begin
            res_hi = sign_a ? -rem : rem;
            if (dbz) begin
                res_lo = '1;
            end else begin
                res_lo = (sign_a ^ sign_b) ? -quo : quo;
            end
        end else begin
            res_hi = prod_fixed[2*NB_DATA-1:NB_DATA];
            res_lo = prod_fixed[NB_DATA-1:0];
        end
    end

    // Operand latch on start, then one shift-add or restore-subtract step per cycle.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            opa    <= '0;
            opb    <= '0;
            acc    <= '0;
            count  <= '0;
            is_div <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            dbz    <= 1'b0;
        end else if (load) begin
            opa    <= abs_rs;
            opb    <= abs_rt;
            acc    <= '0;
            count  <= '0;
            is_div <= i_op[1];
            sign_a <= signed_op & i_rs_data[NB_DATA-1];
            sign_b <= signed_op & i_rt_data[NB_DATA-1];
            dbz    <= i_op[1] & (i_rt_data == '0);
        end else if (step) begin
            count <= count + NB_COUNT'(1);
            if (is_div) begin
                acc <= {rem_next, acc[NB_DATA-2:0], div_ge};
                opa <= opa << 1;
            end else begin
                acc <= {mul_sum, acc[NB_DATA-1:1]};
                opb <= opb >> 1;
            end
        end
    end

    // HI/LO update from a finished operation or from MTHI/MTLO, plus completion pulses.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_hi          <= '0;
            o_lo          <= '0;
            o_done        <= 1'b0;
            o_div_by_zero <= 1'b0;
        end else begin
            o_done        <= commit;
            o_div_by_zero <= commit & dbz;
            if (commit) begin
                o_hi <= res_hi;
                o_lo <= res_lo;
            end else begin
                if (hi_write) begin
                    o_hi <= i_wdata;
                end
                if (lo_write) begin
                    o_lo <= i_wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed and randomized checks of muldiv_sequencer
// against an arithmetic reference model of MULT/MULTU/DIV/DIVU.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        flush;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int          test_count = 0;
    int          fail_count = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    muldiv_sequencer #(
        .NB_DATA (32),
        .NB_OP   (2),
        .NB_COUNT(6)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_start      (start),
        .i_op         (op),
        .i_rs_data    (rs_data),
        .i_rt_data    (rt_data),
        .i_flush      (flush),
        .i_hi_we      (hi_we),
        .i_lo_we      (lo_we),
        .i_wdata      (wdata),
        .o_hi         (hi),
        .o_lo         (lo),
        .o_busy       (busy),
        .o_done       (done),
        .o_div_by_zero(div_by_zero)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Backstop so the run always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        test_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Reference results computed with plain 64-bit arithmetic.
    task automatic reference_model(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] mhi, output logic [31:0] mlo, output logic mdz);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        logic [63:0] q;
        logic [63:0] r;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        mdz = 1'b0;
        case (mop)
            2'b00: begin
                p   = 64'(sa * sb);
                mhi = p[63:32];
                mlo = p[31:0];
            end
            2'b01: begin
                p   = {32'b0, a} * {32'b0, b};
                mhi = p[63:32];
                mlo = p[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    mdz = 1'b1;
                    mlo = 32'hFFFF_FFFF;
                    mhi = a;
                end else if (mop == 2'b10) begin
                    q   = 64'(sa / sb);
                    r   = 64'(sa % sb);
                    mlo = q[31:0];
                    mhi = r[31:0];
                end else begin
                    mlo = a / b;
                    mhi = a % b;
                end
            end
        endcase
    endtask

    // Issue one operation and follow it to completion. inject_at < 0: plain run;
    // 0: MTLO together with the start; > 0: stray start + MTLO at that cycle of RUN.
    task automatic run_op(input string tag, input logic [1:0] mop, input logic [31:0] a,
                          input logic [31:0] b, input int inject_at);
        logic [31:0] mhi;
        logic [31:0] mlo;
        logic        mdz;
        logic [31:0] lo_before;
        int          edges;
        int          busy_cycles;
        int          check_at;
        reference_model(mop, a, b, mhi, mlo, mdz);
        lo_before = exp_lo;
        check_at  = (inject_at == 0) ? 0 : inject_at + 1;
        start     = 1'b1;
        op        = mop;
        rs_data   = a;
        rt_data   = b;
        lo_we     = (inject_at == 0);
        wdata     = 32'h1234_5678;
        @(posedge clk);
        #1;
        start   = 1'b0;
        lo_we   = 1'b0;
        rs_data = $urandom;
        rt_data = $urandom;
        edges       = 0;
        busy_cycles = 0;
        while (done !== 1'b1 && edges < 60) begin
            if (busy === 1'b1) busy_cycles++;
            if (inject_at >= 0 && edges == check_at) begin
                check({tag, "_lo_hold"}, lo, lo_before);
            end
            if (inject_at > 0 && edges == inject_at) begin
                start   = 1'b1;
                op      = 2'($urandom_range(0, 3));
                rs_data = $urandom;
                rt_data = $urandom;
                lo_we   = 1'b1;
                wdata   = $urandom;
            end
            @(posedge clk);
            #1;
            edges++;
            start = 1'b0;
            lo_we = 1'b0;
        end
        check({tag, "_latency"}, 32'(edges), 32'd33);
        check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd33);
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
        check({tag, "_hi"}, hi, mhi);
        check({tag, "_lo"}, lo, mlo);
        check({tag, "_dbz"}, 32'(div_by_zero), 32'(mdz));
        exp_hi = mhi;
        exp_lo = mlo;
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_dbz_pulse"}, 32'(div_by_zero), 32'd0);
    endtask

    task automatic mt_write(input logic hi_en, input logic lo_en, input logic [31:0] data);
        hi_we = hi_en;
        lo_we = lo_en;
        wdata = data;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        lo_we = 1'b0;
        if (hi_en) exp_hi = data;
        if (lo_en) exp_lo = data;
    endtask

    // Linear sequence of directed steps followed by randomized operations.
    initial begin
        int          done_seen;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int          sel;

        rst_n   = 1'b0;
        start   = 1'b0;
        op      = 2'b00;
        rs_data = '0;
        rt_data = '0;
        flush   = 1'b0;
        hi_we   = 1'b0;
        lo_we   = 1'b0;
        wdata   = '0;
        #12;
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("multu_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        check("multu_ff_hi_const", hi, 32'hFFFF_FFFE);
        check("multu_ff_lo_const", lo, 32'h0000_0001);
        run_op("mult_m3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, -1);
        check("mult_m3x5_lo_const", lo, 32'hFFFF_FFF1);
        run_op("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000, -1);
        check("mult_min_hi_const", hi, 32'h4000_0000);
        run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, -1);
        check("div_m7_2_lo_const", lo, 32'hFFFF_FFFD);
        run_op("divu_100_7", 2'b11, 32'd100, 32'd7, -1);
        check("divu_100_7_lo_const", lo, 32'd14);
        run_op("divu_by0", 2'b11, 32'h1234_5678, 32'd0, -1);
        check("divu_by0_hi_const", hi, 32'h1234_5678);
        run_op("div_neg_by0", 2'b10, 32'hFFFF_FF00, 32'd0, -1);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        check("div_ovf_lo_const", lo, 32'h8000_0000);

        mt_write(1'b1, 1'b0, 32'h0000_00AA);
        mt_write(1'b0, 1'b1, 32'h0000_0055);
        check("mthi", hi, 32'h0000_00AA);
        check("mtlo", lo, 32'h0000_0055);
        start   = 1'b1;
        op      = 2'b01;
        rs_data = 32'd3;
        rt_data = 32'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) done_seen++;
        end
        check("flush_no_done", 32'(done_seen), 32'd0);
        check("flush_hi_kept", hi, 32'h0000_00AA);
        check("flush_lo_kept", lo, 32'h0000_0055);
        start = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        check("flush_start_suppressed", 32'(busy), 32'd0);
        run_op("after_flush", 2'b01, 32'd3, 32'd4, -1);

        mt_write(1'b1, 1'b1, 32'hCAFE_F00D);
        check("mt_both_hi", hi, 32'hCAFE_F00D);
        check("mt_both_lo", lo, 32'hCAFE_F00D);
        run_op("start_with_mtlo", 2'b00, 32'd7, 32'hFFFF_FFFE, 0);
        run_op("stray_in_run", 2'b10, 32'd1000, 32'hFFFF_FFF3, 5);
        run_op("stray_late_run", 2'b01, 32'hDEAD_BEEF, 32'h0000_1001, 30);

        start   = 1'b1;
        op      = 2'b10;
        rs_data = 32'hFFFF_FF9C;
        rt_data = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_hi", hi, 32'd0);
        check("async_rst_lo", lo, 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        exp_hi = '0;
        exp_lo = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_idle", 32'(busy), 32'd0);
        run_op("post_rst_div", 2'b10, 32'hFFFF_FF9C, 32'd7, -1);

        for (int n = 0; n < 16; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) begin
                rb = 32'd0;
            end else if (sel == 1) begin
                rb = 32'($urandom_range(1, 15));
            end else if (sel == 2) begin
                rb = 32'hFFFF_FFFF;
            end else begin
                rb = $urandom;
            end
            run_op("random", rop, ra, rb, -1);
        end

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle multiply/divide unit for the execute stage.
- Serves MULT, MULTU, DIV and DIVU. Owns the HI/LO architectural registers.
- Runs an iterative shift-add multiply or restoring divide, one bit per cycle.
- Drives o_busy so the hazard unit can stall the pipeline. Also services MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO.

Parameters:
- NB_DATA, 32, operand and HI/LO width.
- NB_OP, 2, operation select width.
- NB_COUNT, 6, iteration counter width; must hold NB_DATA.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_start  input  1  start request from execute (MULT/MULTU/DIV/DIVU decoded).
- i_op  input  NB_OP  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- i_rs_data  input  NB_DATA  multiplicand / dividend.
- i_rt_data  input  NB_DATA  multiplier / divisor.
- i_flush  input  1  abort the in-flight operation.
- i_hi_we  input  1  MTHI write strobe.
- i_lo_we  input  1  MTLO write strobe.
- i_wdata  input  NB_DATA  MTHI/MTLO data.
- o_hi  output  NB_DATA  HI register.
- o_lo  output  NB_DATA  LO register.
- o_busy  output  1  operation in flight (registered).
- o_done  output  1  one-cycle pulse: HI/LO just updated by an operation.
- o_div_by_zero  output  1  one-cycle pulse with o_done when the divisor was 0.

Behaviour:
- Reset (async, i_reset_n=0): state IDLE; o_hi, o_lo, o_busy, o_done, o_div_by_zero, counter and internal operand/accumulator regs all 0.
- States:
  - IDLE: i_start=1 at edge E0 latches operands, op, and the sign flags (signed ops only). Latches absolute values of the operands. Clears counter and accumulator. Goes to RUN; o_busy=1 from E0.
  - RUN: one iteration per edge. Multiply: add if LSB, then shift right into a 2*NB_DATA accumulator. Divide: shift remainder left, trial-subtract, set quotient bit. Counter increments each edge. After NB_DATA iterations (edge E32) go to FIX.
  - FIX, at edge E33:
    - Apply sign correction. Signed product is negated if operand signs differ. Signed quotient is negated if signs differ. Signed remainder takes the sign of the dividend.
    - Write HI/LO: multiply gives HI = upper half, LO = lower half. Divide gives LO = quotient, HI = remainder.
    - o_done=1 for exactly one cycle, o_busy=0, return to IDLE.
- Latency: start edge to HI/LO valid = 33 edges, identical for every op including divide-by-zero.
- Divide by zero: no trap. LO = all ones, HI = i_rs_data as latched, with no sign correction. o_div_by_zero pulses with o_done.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000 (two's-complement wrap), HI = 0.
- i_start while o_busy=1 is ignored; the in-flight operation is unaffected.
- i_flush in RUN or FIX aborts to IDLE on that edge. o_busy=0 next cycle, HI/LO unchanged, no o_done. i_flush together with i_start in IDLE suppresses the start.
- MTHI/MTLO: in IDLE, i_hi_we/i_lo_we write i_wdata into HI/LO on the edge. Both strobes may fire in the same cycle. Writes while busy are dropped. i_start in the same IDLE cycle wins and the write is dropped.
- o_hi/o_lo are plain register outputs. The hazard unit must stall MFHI/MFLO while o_busy=1.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> o_busy high 33 cycles; o_done one cycle after E33; HI=0xFFFFFFFE, LO=0x00000001.
- MULT -3 (0xFFFFFFFD) × 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. Then MULT 0x80000000 × 0x80000000 -> HI=0x40000000, LO=0.
- DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100 / 7 -> LO=14, HI=2.
- DIVU 0x12345678 / 0 -> LO=0xFFFFFFFF, HI=0x12345678; o_div_by_zero and o_done pulse together. DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
- MTHI 0xAA, MTLO 0x55, then MULTU 3×4 with i_flush at cycle 10 -> no o_done; HI=0xAA, LO=0x55 retained; new start next cycle completes normally. Also: i_start and MTLO written during RUN are ignored.
- i_reset_n low at cycle 15 of a DIV -> all outputs 0 immediately (asynchronous); after release the block is IDLE and accepts a start.
